// File: rtl/reg_pkg.sv
// Shared definitions for the bit register bank: op encodings and width helper.
// Latency: none (constants and pure functions only).
// Backpressure: none.
package reg_pkg;

  // Bit-operation encodings carried on the 2-bit op input.
  localparam logic [1:0] OP_WRITE  = 2'b00;  // bit <= bit_in
  localparam logic [1:0] OP_SET    = 2'b01;  // bit <= 1
  localparam logic [1:0] OP_RESET  = 2'b10;  // bit <= 0
  localparam logic [1:0] OP_TOGGLE = 2'b11;  // bit <= ~bit

  // Address width for a given word count; a single-word bank still gets a
  // one-bit address so the port never collapses to zero width.
  function automatic int addr_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/bit_sel_decoder.sv
// One-hot decoder turning a bit index into a write mask.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   sel  - bit index within the word
//   en   - decode enable; mask is all zero when low
//   mask - one-hot mask, all zero when disabled or sel >= WIDTH
module bit_sel_decoder #(
  parameter int WIDTH = 8,
  localparam int BW = $clog2(WIDTH)
) (
  input  logic [BW-1:0]    sel,
  input  logic             en,
  output logic [WIDTH-1:0] mask
);

  // Only indices below WIDTH are compared, so an out-of-range select
  // matches nothing and the mask stays zero.
  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = en && (int'(sel) == i);
    end
  end

endmodule

// File: rtl/bit_register_bank.sv
// Bank of WORDS x WIDTH registers with per-bit ops, word writes and edge flags.
// Latency: writes land on the clock edge; reads are registered, 1 cycle (read-old).
// Backpressure: none; every strobe is accepted in the cycle it is presented.
//
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   wr_en, op, bit_sel, bit_in      - single-bit operation on word_addr
//   word_wr_en, word_in             - full-word write to word_addr
//   rd_addr, rd_bit_sel             - read word / bit select
//   rd_data, rd_bit                 - registered read word and selected bit
//   rd_rise, rd_fall                - registered 0->1 / 1->0 flags of the read word
//   addr_err                        - one-cycle pulse on an out-of-range write
module bit_register_bank
  import reg_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int WIDTH = 8,
  localparam int AW = addr_width(WORDS),
  localparam int BW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    word_addr,
  input  logic [BW-1:0]    bit_sel,
  input  logic             bit_in,
  input  logic             word_wr_en,
  input  logic [WIDTH-1:0] word_in,
  input  logic [AW-1:0]    rd_addr,
  input  logic [BW-1:0]    rd_bit_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_bit,
  output logic [WIDTH-1:0] rd_rise,
  output logic [WIDTH-1:0] rd_fall,
  output logic             addr_err
);

  // Limits widened by one bit so the compare is exact even when WORDS or
  // WIDTH is a power of two.
  localparam logic [AW:0] WORDS_LIM = (AW + 1)'(WORDS);
  localparam logic [BW:0] WIDTH_LIM = (BW + 1)'(WIDTH);

  logic [WIDTH-1:0] mem      [WORDS];
  logic [WIDTH-1:0] prev     [WORDS];
  logic [WIDTH-1:0] mem_next [WORDS];

  logic             addr_ok;
  logic             bit_ok;
  logic             err_next;
  logic [WIDTH-1:0] bit_mask;
  logic             hit;
  logic [WIDTH-1:0] word_res;
  logic [WIDTH-1:0] op_res;
  logic [WIDTH-1:0] mask_w;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] rd_prev;
  logic [BW-1:0]    rd_sel_q;

  assign addr_ok = {1'b0, word_addr} < WORDS_LIM;
  assign bit_ok  = {1'b0, bit_sel} < WIDTH_LIM;

  // A bit op with a bad word or bit index is dropped; a word write only
  // cares about the word index.
  assign err_next = (wr_en && (!addr_ok || !bit_ok)) || (word_wr_en && !addr_ok);

  bit_sel_decoder #(
    .WIDTH (WIDTH)
  ) u_bit_sel_decoder (
    .sel  (bit_sel),
    .en   (wr_en),
    .mask (bit_mask)
  );

  // Per-word next state. The word write is resolved first so that a bit op
  // in the same cycle overlays it, and TOGGLE inverts the freshly written
  // value. An out-of-range word_addr matches no word, so nothing changes.
  always_comb begin
    hit      = 1'b0;
    word_res = '0;
    op_res   = '0;
    mask_w   = '0;
    for (int w = 0; w < WORDS; w++) begin
      hit      = (word_addr == AW'(w));
      word_res = (word_wr_en && hit) ? word_in : mem[w];
      case (op)
        OP_WRITE:  op_res = {WIDTH{bit_in}};
        OP_SET:    op_res = '1;
        OP_RESET:  op_res = '0;
        default:   op_res = ~word_res;
      endcase
      mask_w      = hit ? bit_mask : '0;
      mem_next[w] = (word_res & ~mask_w) | (op_res & mask_w);
    end
  end

  // Read mux; an out-of-range rd_addr falls through to zero for both the
  // data and the snapshot, which also zeroes the edge flags.
  always_comb begin
    rd_word = '0;
    rd_prev = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (rd_addr == AW'(w)) begin
        rd_word = mem[w];
        rd_prev = prev[w];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WORDS; w++) begin
        mem[w]  <= '0;
        prev[w] <= '0;
      end
      rd_data  <= '0;
      rd_rise  <= '0;
      rd_fall  <= '0;
      rd_sel_q <= '0;
      addr_err <= 1'b0;
    end else begin
      for (int w = 0; w < WORDS; w++) begin
        mem[w]  <= mem_next[w];
        prev[w] <= mem[w];
      end
      rd_data  <= rd_word;
      rd_rise  <= rd_word & ~rd_prev;
      rd_fall  <= ~rd_word & rd_prev;
      rd_sel_q <= rd_bit_sel;
      addr_err <= err_next;
    end
  end

  // Selected bit of the registered word; a select past WIDTH yields 0.
  always_comb begin
    rd_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (rd_sel_q == BW'(i)) begin
        rd_bit = rd_data[i];
      end
    end
  end

endmodule

// File: tb/tb_bit_register_bank.sv
// Directed testbench for bit_register_bank (WORDS=3, WIDTH=8).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// No backpressure to model; each step is one clock cycle.
module tb_bit_register_bank;

  localparam int WORDS = 3;
  localparam int WIDTH = 8;
  localparam int AW = 2;
  localparam int BW = 3;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [1:0]       op;
  logic [AW-1:0]    word_addr;
  logic [BW-1:0]    bit_sel;
  logic             bit_in;
  logic             word_wr_en;
  logic [WIDTH-1:0] word_in;
  logic [AW-1:0]    rd_addr;
  logic [BW-1:0]    rd_bit_sel;
  logic [WIDTH-1:0] rd_data;
  logic             rd_bit;
  logic [WIDTH-1:0] rd_rise;
  logic [WIDTH-1:0] rd_fall;
  logic             addr_err;

  int n_checks = 0;
  int n_pass   = 0;

  bit_register_bank #(
    .WORDS (WORDS),
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .op         (op),
    .word_addr  (word_addr),
    .bit_sel    (bit_sel),
    .bit_in     (bit_in),
    .word_wr_en (word_wr_en),
    .word_in    (word_in),
    .rd_addr    (rd_addr),
    .rd_bit_sel (rd_bit_sel),
    .rd_data    (rd_data),
    .rd_bit     (rd_bit),
    .rd_rise    (rd_rise),
    .rd_fall    (rd_fall),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en      = 1'b0;
    word_wr_en = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    wr_en      = 1'b0;
    op         = 2'b00;
    word_addr  = '0;
    bit_sel    = '0;
    bit_in     = 1'b0;
    word_wr_en = 1'b0;
    word_in    = '0;
    rd_addr    = '0;
    rd_bit_sel = '0;

    // Reset state
    #2;
    check("rst_rd_data", 32'(rd_data), 32'h00);
    check("rst_rd_rise", 32'(rd_rise), 32'h00);
    check("rst_rd_fall", 32'(rd_fall), 32'h00);
    check("rst_rd_bit", 32'(rd_bit), 32'h0);
    check("rst_addr_err", 32'(addr_err), 32'h0);
    #10 rst_n = 1'b1;

    // SET word 2 bit 5, read it back and watch the rise flag pulse once.
    wr_en = 1'b1; op = 2'b01; word_addr = 2'd2; bit_sel = 3'd5;
    rd_addr = 2'd2; rd_bit_sel = 3'd5;
    step();
    idle();
    step();
    check("set_rd_data", 32'(rd_data), 32'h20);
    check("set_rd_rise", 32'(rd_rise), 32'h20);
    check("set_rd_bit", 32'(rd_bit), 32'h1);
    check("set_addr_err", 32'(addr_err), 32'h0);
    step();
    check("set_rise_clear", 32'(rd_rise), 32'h00);
    check("set_rd_data_hold", 32'(rd_data), 32'h20);

    // Word write 0xA5 to word 1, then TOGGLE bit 0 on two consecutive edges.
    word_wr_en = 1'b1; word_addr = 2'd1; word_in = 8'hA5;
    rd_addr = 2'd1; rd_bit_sel = 3'd0;
    step();
    word_wr_en = 1'b0;
    wr_en = 1'b1; op = 2'b11; bit_sel = 3'd0;
    step();
    check("tgl_rd_data0", 32'(rd_data), 32'hA5);
    check("tgl_rise0", 32'(rd_rise), 32'hA5);
    step();
    idle();
    check("tgl_rd_data1", 32'(rd_data), 32'hA4);
    check("tgl_fall1", 32'(rd_fall), 32'h01);
    check("tgl_rise1", 32'(rd_rise), 32'h00);
    check("tgl_rd_bit1", 32'(rd_bit), 32'h0);
    step();
    check("tgl_rd_data2", 32'(rd_data), 32'hA5);
    check("tgl_rise2", 32'(rd_rise), 32'h01);
    check("tgl_fall2", 32'(rd_fall), 32'h00);

    // Word write 0xFF and RESET bit 3 to word 0 in the same cycle.
    word_wr_en = 1'b1; word_in = 8'hFF;
    wr_en = 1'b1; op = 2'b10; word_addr = 2'd0; bit_sel = 3'd3;
    rd_addr = 2'd0;
    step();
    idle();
    step();
    check("both_w0", 32'(rd_data), 32'hF7);
    rd_addr = 2'd1;
    step();
    check("both_w1", 32'(rd_data), 32'hA5);
    rd_addr = 2'd2;
    step();
    check("both_w2", 32'(rd_data), 32'h20);

    // Out-of-range word address: one-cycle error pulse, storage untouched.
    word_wr_en = 1'b1; word_addr = 2'd3; word_in = 8'h5A; rd_addr = 2'd3;
    step();
    idle();
    check("oor_word_err", 32'(addr_err), 32'h1);
    check("oor_rd_data", 32'(rd_data), 32'h00);
    check("oor_rd_rise", 32'(rd_rise), 32'h00);
    step();
    check("oor_err_pulse", 32'(addr_err), 32'h0);
    wr_en = 1'b1; op = 2'b01; word_addr = 2'd3; bit_sel = 3'd0;
    step();
    idle();
    check("oor_bit_err", 32'(addr_err), 32'h1);
    rd_addr = 2'd0;
    step();
    check("oor_err_clear", 32'(addr_err), 32'h0);
    check("oor_w0", 32'(rd_data), 32'hF7);
    rd_addr = 2'd1;
    step();
    check("oor_w1", 32'(rd_data), 32'hA5);
    rd_addr = 2'd2;
    step();
    check("oor_w2", 32'(rd_data), 32'h20);

    // Asynchronous reset in the middle of a write burst.
    wr_en = 1'b1; op = 2'b01; word_addr = 2'd2; bit_sel = 3'd1;
    rd_addr = 2'd2; rd_bit_sel = 3'd5;
    step();
    word_addr = 2'd3;
    step();
    check("burst_err", 32'(addr_err), 32'h1);
    check("burst_rd_data", 32'(rd_data), 32'h22);
    word_addr = 2'd2; bit_sel = 3'd6;
    #3 rst_n = 1'b0;
    #1;
    check("arst_rd_data", 32'(rd_data), 32'h00);
    check("arst_rd_rise", 32'(rd_rise), 32'h00);
    check("arst_rd_bit", 32'(rd_bit), 32'h0);
    check("arst_addr_err", 32'(addr_err), 32'h0);
    idle();
    #2 rst_n = 1'b1;
    step();
    check("arst_w2_after", 32'(rd_data), 32'h00);
    check("arst_fall_after", 32'(rd_fall), 32'h00);

    // WRITE bit 7 of word 0 while reading it on the same edge: read-old.
    wr_en = 1'b1; op = 2'b00; word_addr = 2'd0; bit_sel = 3'd7; bit_in = 1'b1;
    rd_addr = 2'd0; rd_bit_sel = 3'd7;
    step();
    idle();
    check("rdold_data", 32'(rd_data), 32'h00);
    check("rdold_bit", 32'(rd_bit), 32'h0);
    step();
    check("rdnew_data", 32'(rd_data), 32'h80);
    check("rdnew_bit", 32'(rd_bit), 32'h1);
    check("rdnew_rise", 32'(rd_rise), 32'h80);
    wr_en = 1'b1; bit_in = 1'b0;
    step();
    idle();
    step();
    check("wr0_data", 32'(rd_data), 32'h00);
    check("wr0_fall", 32'(rd_fall), 32'h80);
    check("wr0_rise", 32'(rd_rise), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
